// File: rtl/div_seq_pkg.sv
// Shared definitions for the EX-stage divide sequencer.
// Holds the FSM state encoding, result bus width and stall-bus layout.
package div_seq_pkg;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    localparam int DIV_WIDTH    = 32;
    localparam int DivResultBus = 2 * DIV_WIDTH;

    // Stall bus: one bit per pipeline stage, EX owns a single bit.
    localparam int STALL_BUS_W  = 6;
    localparam int STALL_EX_W   = 1;
    localparam int STALL_EX_IDX = 3;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration (combinational).
// Ports: rem_i partial remainder, bit_i next dividend bit, dvs_i divisor,
//        rem_o new partial remainder, q_o quotient bit produced.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem_i < dvs_i always holds, so the trial difference lies in
    // (-2^WIDTH, 2^WIDTH) and its top bit is a valid sign flag.
    assign shifted = {rem_i, bit_i};
    assign diff    = shifted - {1'b0, dvs_i};
    assign q_o     = ~diff[WIDTH];
    assign rem_o   = q_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU sequencer beside EX; stalls the pipe while busy.
// Ports: clk, rst (sync, active-high), flush, start_i, signed_i,
//        opdata1_i dividend, opdata2_i divisor,
//        result_o {rem, quot}, ready_o, stallreq_o.
module div_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stallreq_o
);

    import div_seq_pkg::*;

    div_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               neg_dvd_q, neg_dvd_d;
    logic               neg_dvs_q, neg_dvs_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;

    logic [WIDTH-1:0]   step_rem;
    logic               step_q;
    logic               last;
    logic               op1_neg, op2_neg;
    logic [WIDTH-1:0]   op1_abs, op2_abs;
    logic [WIDTH-1:0]   quot_raw, quot_fix, rem_fix;

    // The dividend register doubles as the quotient register: each step
    // shifts a dividend bit out of the top and a quotient bit in below.
    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i (rem_q),
        .bit_i (dvd_q[WIDTH-1]),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    assign last     = (cnt_q == CNT_W'(WIDTH - 1));
    assign op1_neg  = signed_i & opdata1_i[WIDTH-1];
    assign op2_neg  = signed_i & opdata2_i[WIDTH-1];
    assign op1_abs  = op1_neg ? -opdata1_i : opdata1_i;
    assign op2_abs  = op2_neg ? -opdata2_i : opdata2_i;
    assign quot_raw = {dvd_q[WIDTH-2:0], step_q};
    // Neg flags are only set for DIV, so DIVU passes through unchanged.
    assign quot_fix = (neg_dvd_q ^ neg_dvs_q) ? -quot_raw : quot_raw;
    assign rem_fix  = neg_dvd_q ? -step_rem : step_rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DIV_FREE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = DIV_FREE;
        end else begin
            unique case (state_q)
                DIV_FREE: begin
                    if (start_i) begin
                        state_d = (opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
                    end
                end
                DIV_BYZERO: state_d = DIV_END;
                DIV_ON: begin
                    if (last) begin
                        state_d = DIV_END;
                    end
                end
                DIV_END: begin
                    if (!start_i) begin
                        state_d = DIV_FREE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        stallreq_o = 1'b0;
        unique case (state_q)
            DIV_FREE:   stallreq_o = start_i & ~flush;
            DIV_BYZERO: stallreq_o = 1'b1;
            DIV_ON:     stallreq_o = 1'b1;
            DIV_END:    stallreq_o = 1'b0;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        neg_dvd_d = neg_dvd_q;
        neg_dvs_d = neg_dvs_q;
        result_d  = result_q;
        if (flush) begin
            cnt_d    = '0;
            result_d = '0;
        end else begin
            unique case (state_q)
                DIV_FREE: begin
                    result_d = '0;
                    if (start_i) begin
                        dvd_d     = op1_abs;
                        dvs_d     = op2_abs;
                        neg_dvd_d = op1_neg;
                        neg_dvs_d = op2_neg;
                        rem_d     = '0;
                        cnt_d     = '0;
                    end
                end
                DIV_BYZERO: result_d = '0;
                DIV_ON: begin
                    rem_d = step_rem;
                    dvd_d = quot_raw;
                    cnt_d = cnt_q + 1'b1;
                    if (last) begin
                        result_d = {rem_fix, quot_fix};
                    end
                end
                DIV_END: begin
                    if (!start_i) begin
                        result_d = '0;
                    end
                end
            endcase
        end
        ready_d = (state_d == DIV_END);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            neg_dvd_q <= 1'b0;
            neg_dvs_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            neg_dvd_q <= neg_dvd_d;
            neg_dvs_q <= neg_dvs_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq against an arithmetic reference model.
// Random and directed DIV/DIVU, divide-by-zero, flush, hold and reset.
module tb_div_seq;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          start;
    logic          sgn;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [2*W-1:0] res;
    logic          rdy;
    logic          stall;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    div_seq #(
        .WIDTH (W),
        .CNT_W (6)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .start_i    (start),
        .signed_i   (sgn),
        .opdata1_i  (a),
        .opdata2_i  (b),
        .result_o   (res),
        .ready_o    (rdy),
        .stallreq_o (stall)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // {remainder, quotient} from plain 64-bit arithmetic; SV division
    // truncates toward zero, so the remainder follows the dividend sign.
    function automatic logic [63:0] model(input bit s,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
        longint sx, sy, q, r;
        if (y == 0) return 64'd0;
        if (s) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
        end else begin
            sx = {32'd0, x};
            sy = {32'd0, y};
        end
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_div(input bit s, input logic [31:0] x,
                           input logic [31:0] y, input int hold);
        logic [63:0] exp;
        int n;
        bit done;
        exp   = model(s, x, y);
        sgn   = s;
        a     = x;
        b     = y;
        start = 1'b1;
        #1;
        chk("stall_first", {63'd0, stall}, 64'd1);
        n    = 0;
        done = 1'b0;
        while (!done && n < 40) begin
            step();
            n++;
            a   = $urandom;
            b   = $urandom;
            sgn = 1'($urandom);
            #1;
            if (rdy) done = 1'b1;
            else chk("stall_busy", {63'd0, stall}, 64'd1);
        end
        chk("latency", 64'(n), (y == 0) ? 64'd2 : 64'(W + 1));
        chk("ready", {63'd0, rdy}, 64'd1);
        chk("result", res, exp);
        chk("stall_end", {63'd0, stall}, 64'd0);
        for (int i = 0; i < hold; i++) begin
            step();
            chk("hold_rdy", {63'd0, rdy}, 64'd1);
            chk("hold_res", res, exp);
        end
        start = 1'b0;
        #1;
        chk("drop_stall", {63'd0, stall}, 64'd0);
        step();
        chk("free_rdy", {63'd0, rdy}, 64'd0);
        chk("free_res", res, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst   = 1'b1;
        flush = 1'b0;
        start = 1'b0;
        sgn   = 1'b0;
        a     = '0;
        b     = '0;
        step();
        step();
        chk("rst_rdy", {63'd0, rdy}, 64'd0);
        chk("rst_res", res, 64'd0);
        chk("rst_stall", {63'd0, stall}, 64'd0);
        rst = 1'b0;
        step();

        run_div(1'b0, 32'd7, 32'd2, 0);
        chk("k_divu", res, 64'd0);
        run_div(1'b1, 32'hFFFFFFF9, 32'd2, 0);
        run_div(1'b1, 32'd5, 32'd0, 0);

        // Flush at t+10 while ON.
        sgn   = 1'b0;
        a     = 32'd100;
        b     = 32'd3;
        start = 1'b1;
        repeat (10) step();
        chk("flush_on_stall", {63'd0, stall}, 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        start = 1'b0;
        #1;
        chk("flush_stall", {63'd0, stall}, 64'd0);
        chk("flush_rdy", {63'd0, rdy}, 64'd0);
        chk("flush_res", res, 64'd0);
        seen = 0;
        repeat (40) begin
            step();
            if (rdy) seen++;
        end
        chk("flush_no_rdy", 64'(seen), 64'd0);
        run_div(1'b0, 32'hFFFFFFFF, 32'd1, 0);

        // Flush beats a start in the same cycle.
        sgn   = 1'b0;
        a     = 32'd9;
        b     = 32'd4;
        start = 1'b1;
        flush = 1'b1;
        #1;
        chk("prio_stall", {63'd0, stall}, 64'd0);
        step();
        flush = 1'b0;
        start = 1'b0;
        #1;
        chk("prio_free", {63'd0, stall}, 64'd0);
        step();

        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 3);

        // Reset while ON.
        sgn   = 1'b1;
        a     = 32'h12345678;
        b     = 32'd7;
        start = 1'b1;
        repeat (5) step();
        rst = 1'b1;
        step();
        rst   = 1'b0;
        start = 1'b0;
        #1;
        chk("rston_rdy", {63'd0, rdy}, 64'd0);
        chk("rston_res", res, 64'd0);
        chk("rston_stall", {63'd0, stall}, 64'd0);
        step();

        // Reset while holding a result in END.
        sgn   = 1'b0;
        a     = 32'd3;
        b     = 32'd1;
        start = 1'b1;
        repeat (W + 1) step();
        chk("rstend_pre", res, 64'd3);
        rst = 1'b1;
        step();
        rst   = 1'b0;
        start = 1'b0;
        #1;
        chk("rstend_rdy", {63'd0, rdy}, 64'd0);
        chk("rstend_res", res, 64'd0);
        step();

        for (int k = 0; k < 16; k++) begin
            logic [31:0] x, y;
            x = $urandom;
            case ($urandom_range(0, 3))
                0: y = 32'd0;
                1: y = 32'($urandom_range(1, 15));
                2: y = -32'($urandom_range(1, 15));
                default: y = $urandom;
            endcase
            run_div(1'($urandom), x, y, $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
